// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack reads to instruction memory and feeds the F->D register.
// Optional FETCH_MISALIGN_CHK_EN: adds misalign_o and forces redirect targets to word alignment.
module fetch_unit #(
    parameter int unsigned                 ADDRESS_WIDTH = 32,
    parameter int unsigned                 DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0]       NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                     misalign_o
`endif
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    localparam logic [ADDRESS_WIDTH-1:0] Four = ADDRESS_WIDTH'(4);

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] redir_q;
    logic [DATA_WIDTH-1:0]    hold_q;
    logic [ADDRESS_WIDTH-1:0] hold_pc_q;
    logic [ADDRESS_WIDTH-1:0] target;
    logic                     blocked;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;
    assign target     = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
    assign misaligned = redirect_pc_i[1:0] != 2'b00;
`else
    assign target = redirect_pc_i;
`endif

    assign blocked = valid_o && stall_i;

    // pc_q only moves on ack or on redirect-from-HOLD, so the address stays put while a read is open
    assign imem_req_o  = rst_ni && (state_q != StHold);
    assign imem_addr_o = pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            redir_q    <= '0;
            hold_q     <= NOP_INSTR;
            hold_pc_q  <= '0;
            valid_o    <= 1'b0;
            instr_o    <= NOP_INSTR;
            pc_o       <= '0;
            pc_plus4_o <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_o <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_o <= redirect_i && misaligned;
`endif
            case (state_q)
                StFetch: begin
                    if (redirect_i) begin
                        valid_o <= 1'b0;
                        instr_o <= NOP_INSTR;
                        if (imem_ack_i) begin
                            pc_q <= target;
                        end else begin
                            redir_q <= target;
                            state_q <= StDrain;
                        end
                    end else if (imem_ack_i) begin
                        pc_q <= pc_q + Four;
                        if (blocked) begin
                            hold_q    <= imem_rdata_i;
                            hold_pc_q <= pc_q;
                            state_q   <= StHold;
                        end else begin
                            valid_o    <= 1'b1;
                            instr_o    <= imem_rdata_i;
                            pc_o       <= pc_q;
                            pc_plus4_o <= pc_q + Four;
                        end
                    end else if (!blocked) begin
                        valid_o <= 1'b0;
                        instr_o <= NOP_INSTR;
                    end
                end
                StHold: begin
                    if (redirect_i) begin
                        valid_o <= 1'b0;
                        instr_o <= NOP_INSTR;
                        pc_q    <= target;
                        state_q <= StFetch;
                    end else if (!stall_i) begin
                        valid_o    <= 1'b1;
                        instr_o    <= hold_q;
                        pc_o       <= hold_pc_q;
                        pc_plus4_o <= hold_pc_q + Four;
                        state_q    <= StFetch;
                    end
                end
                StDrain: begin
                    // The stale response is swallowed; only the latest target survives
                    if (redirect_i) begin
                        valid_o <= 1'b0;
                        instr_o <= NOP_INSTR;
                        if (imem_ack_i) begin
                            pc_q    <= target;
                            state_q <= StFetch;
                        end else begin
                            redir_q <= target;
                        end
                    end else if (imem_ack_i) begin
                        pc_q    <= redir_q;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch-stream model checked every cycle, plus directed scenarios.
// Build with FETCH_MISALIGN_CHK_EN defined to also exercise misalign_o.
module tb_fetch_unit;

    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [31:0] Key = 32'h1357_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign;
`endif

    fetch_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .valid_o      (valid),
        .instr_o      (instr),
        .pc_o         (pc),
        .pc_plus4_o   (pc4)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o   (misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return Key ^ a;
    endfunction

    // Memory: acks once the request has been waiting mem_wait cycles
    int mem_wait = 0;
    int wait_cnt = 0;
    assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
    assign imem_rdata = mem_word(imem_addr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: fetched-but-undelivered instructions sit in a queue; a redirect with a read
    // in flight marks that read to be dropped and remembers where to resume.
    logic        m_valid, m_drop, m_mis, m_req, m_blocked;
    logic [31:0] m_instr, m_pc, m_pc4, m_next, m_target, m_tgt;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_instr = Nop; m_pc = '0; m_pc4 = '0; m_next = '0;
            m_drop = 1'b0; m_target = '0; m_mis = 1'b0;
            q_pc.delete(); q_in.delete();
        end else begin
            m_req     = (q_pc.size() == 0);
            m_blocked = m_valid && stall;
            m_tgt     = redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
            m_tgt[1:0] = 2'b00;
            m_mis      = redirect && (redirect_pc[1:0] != 2'b00);
`endif
            if (redirect) begin
                m_valid = 1'b0; m_instr = Nop;
                q_pc.delete(); q_in.delete();
                if (m_req && !imem_ack) begin
                    m_drop = 1'b1; m_target = m_tgt;
                end else begin
                    m_drop = 1'b0; m_next = m_tgt;
                end
            end else if (m_drop) begin
                if (imem_ack) begin
                    m_drop = 1'b0; m_next = m_target;
                end
            end else begin
                if (m_req && imem_ack) begin
                    q_pc.push_back(m_next);
                    q_in.push_back(mem_word(m_next));
                    m_next = m_next + 32'd4;
                end
                if (!m_blocked) begin
                    if (q_pc.size() > 0) begin
                        m_valid = 1'b1;
                        m_pc    = q_pc.pop_front();
                        m_instr = q_in.pop_front();
                        m_pc4   = m_pc + 32'd4;
                    end else begin
                        m_valid = 1'b0; m_instr = Nop;
                    end
                end
            end
        end
        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_valid", 32'(valid), 32'(m_valid));
            check("m_instr", instr, m_instr);
            if (m_valid) begin
                check("m_pc", pc, m_pc);
                check("m_pc4", pc4, m_pc4);
            end
            check("m_req", 32'(imem_req), 32'(rst_n && (q_pc.size() == 0)));
            if (rst_n && q_pc.size() == 0) check("m_addr", imem_addr, m_next);
`ifdef FETCH_MISALIGN_CHK_EN
            check("m_misalign", 32'(misalign), 32'(m_mis));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr, Nop);
        check("rst_pc", pc, 32'd0);
        check("rst_pc4", pc4, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // Zero-wait streaming
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_valid", 32'(valid), 32'd1);
            check("t1_pc", pc, 32'(i * 4));
            check("t1_pc4", pc4, 32'(i * 4 + 4));
            check("t1_instr", instr, Key | 32'(i * 4));
        end

        // Stall three cycles at pc 8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_pc", pc, 32'h8);
            check("t2_req_low", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("t2_pc_c", pc, 32'hC);
        @(negedge clk);
        check("t2_pc_10", pc, 32'h10);

        // Three-wait memory, redirect mid-wait
        mem_wait = 3;
        @(negedge clk);
        check("t3_bubble", 32'(valid), 32'd0);
        check("t3_addr", imem_addr, 32'h14);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        check("t3_addr_held", imem_addr, 32'h14);
        for (int i = 0; i < 12 && !valid; i++) @(negedge clk);
        check("t3_valid", 32'(valid), 32'd1);
        check("t3_pc", pc, 32'h100);
        check("t3_instr", instr, 32'h1357_0100);

        // Redirect beats stall
        mem_wait = 0;
        @(negedge clk);
        check("t4_pc_104", pc, 32'h104);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        check("t4_valid0", 32'(valid), 32'd0);
        check("t4_nop", instr, Nop);
        redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("t4_pc", pc, 32'h200);

        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        check("t5_pc", pc, 32'hFFFF_FFFC);
        check("t5_pc4", pc4, 32'h0);
        check("t5_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("t5_pc_wrap", pc, 32'h0);

        // Redirect while holding a buffered instruction
        stall = 1'b1;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        check("t7_valid0", 32'(valid), 32'd0);
        redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("t7_pc", pc, 32'h300);

        // Two redirects during a drain: the last one wins
        mem_wait = 2;
        redirect = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        redirect_pc = 32'h500;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 12 && !valid; i++) @(negedge clk);
        check("t8_pc", pc, 32'h500);

`ifdef FETCH_MISALIGN_CHK_EN
        mem_wait = 0;
        redirect = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        check("t6_mis1", 32'(misalign), 32'd1);
        check("t6_addr", imem_addr, 32'h100);
        @(negedge clk);
        check("t6_mis0", 32'(misalign), 32'd0);
        check("t6_pc", pc, 32'h100);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
